// File: rtl/pe_shtsum_pkg.sv
// rtl/pe_shtsum_pkg.sv - shared widths, control word and helpers for the shift-sum stage
package pe_shtsum_pkg;

  localparam int AUODWD  = 16;
  localparam int PSUMDWD = 32;

  typedef enum logic [1:0] {SHT1, SHT2, SHT4, SHT8} ShtNum;

  typedef struct packed {
    logic  valid;
    logic  init;
    logic  fstpix;
    logic  lstpix;
    logic  sht;
    ShtNum sht_num;
  } SSctl;

  localparam int SSCTL_W = $bits(SSctl);

  typedef enum logic {SS_IDLE, SS_ACC} SSstate;

  function automatic logic [4:0] shtAmt(ShtNum n);
    case (n)
      SHT1:    shtAmt = 5'd1;
      SHT2:    shtAmt = 5'd2;
      SHT4:    shtAmt = 5'd4;
      default: shtAmt = 5'd8;
    endcase
  endfunction

endpackage

// File: rtl/pe_shtsum_alu.sv
// rtl/pe_shtsum_alu.sv - combinational shift, sign-extend, add and signed overflow detect
module pe_shtsum_alu
  import pe_shtsum_pkg::*;
(
  input  logic [PSUMDWD-1:0] base,
  input  logic               sht,
  input  logic [1:0]         sht_num,
  input  logic [AUODWD-1:0]  au_sum,
  output logic [PSUMDWD-1:0] sum,
  output logic               ovf
);

  logic [4:0]         amt;
  logic [PSUMDWD-1:0] shifted;
  logic [PSUMDWD-1:0] addend;
  logic               sht_ovf;
  logic               add_ovf;

  always_comb begin
    amt     = shtAmt(ShtNum'(sht_num));
    shifted = sht ? (base << amt) : base;
    // a lossless shift survives an arithmetic shift back unchanged
    sht_ovf = sht && (($signed(shifted) >>> amt) != $signed(base));
    addend  = {{(PSUMDWD-AUODWD){au_sum[AUODWD-1]}}, au_sum};
    sum     = shifted + addend;
    add_ovf = (shifted[PSUMDWD-1] == addend[PSUMDWD-1]) &&
              (sum[PSUMDWD-1] != shifted[PSUMDWD-1]);
    ovf     = sht_ovf | add_ovf;
  end

endmodule

// File: rtl/pe_shtsum.sv
// rtl/pe_shtsum.sv - shift-and-add psum accumulator with one-entry valid/ready output register
module pe_shtsum
  import pe_shtsum_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [SSCTL_W-1:0] i_ctl,
  input  logic [AUODWD-1:0]  i_au_sum,
  input  logic [PSUMDWD-1:0] i_buf_psum,
  output logic               o_ready,
  output logic [PSUMDWD-1:0] o_psum,
  output logic               o_psum_valid,
  input  logic               i_psum_ready,
  output logic               o_ovf,
  output logic               o_acc_busy
);

  SSctl               ctl;
  SSstate             state;
  logic [PSUMDWD-1:0] acc;
  logic [PSUMDWD-1:0] base;
  logic [PSUMDWD-1:0] acc_next;
  logic               alu_ovf;
  logic               fire;
  logic               restart;

  assign ctl        = SSctl'(i_ctl);
  assign o_ready    = !o_psum_valid | i_psum_ready;
  assign fire       = ctl.valid & o_ready;
  assign restart    = ctl.fstpix | ctl.init;
  assign o_acc_busy = (state == SS_ACC);

  always_comb begin
    base = acc;
    if (ctl.fstpix)
      base = '0;
    else if (ctl.init)
      base = i_buf_psum;
  end

  pe_shtsum_alu u_alu (
    .base    (base),
    .sht     (ctl.sht),
    .sht_num (ctl.sht_num),
    .au_sum  (i_au_sum),
    .sum     (acc_next),
    .ovf     (alu_ovf)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= SS_IDLE;
      acc   <= '0;
      o_ovf <= 1'b0;
    end else if (fire) begin
      acc   <= acc_next;
      o_ovf <= restart ? alu_ovf : (o_ovf | alu_ovf);
      case (state)
        SS_IDLE: if (restart && !ctl.lstpix) state <= SS_ACC;
        SS_ACC:  if (ctl.lstpix)             state <= SS_IDLE;
        default:                             state <= SS_IDLE;
      endcase
    end
  end

  // a reload on the accepting cycle keeps the register full
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_psum       <= '0;
      o_psum_valid <= 1'b0;
    end else if (fire && ctl.lstpix) begin
      o_psum       <= acc_next;
      o_psum_valid <= 1'b1;
    end else if (i_psum_ready) begin
      o_psum_valid <= 1'b0;
    end
  end

endmodule
